// File: rtl/tick_timer_pkg.sv
// Shared encodings for the tick timer family.
// Holds the mode encoding for one-shot vs periodic operation and the
// two-state FSM encoding used by tick_timer.
package tick_timer_pkg;

  // Counting mode, latched from i_mode on start
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Timer FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : tick_timer_pkg

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: produces one step strobe every div+1 enabled cycles.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   clr       - force the prescale count back to zero (wins over en)
//   en        - count enable; step_c is only produced while enabled
//   div       - divider D; count runs 0..D
//   step_c    - combinational strobe, high when enabled and count == div
module tick_prescaler #(
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] div,
  output logic                   step_c
);

  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] presc_d;

  assign step_c = en && (presc_q == div);

  // Next prescale count: wraps to zero on each step, never exceeds div
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = step_c ? '0 : presc_q + PRESC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/tick_timer.sv
// Runtime-programmable tick generator with prescaler, periodic/one-shot mode
// and start/stop control. Emits a one-cycle o_tick enable strobe.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   i_period  - terminal count P (tick every P+1 steps), latched on i_start
//   i_presc   - divider D (one step every D+1 cycles), latched on i_start
//   i_mode    - 0 periodic auto-reload, 1 one-shot; latched on i_start
//   i_start   - load config and (re)start from zero; beats i_stop
//   i_stop    - return to idle (ignored while idle)
//   o_tick    - one-cycle strobe at terminal count
//   o_busy    - high while running
//   o_cnt     - current main count value
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_WIDTH-1:0]   i_period,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  input  logic                   i_mode,
  input  logic                   i_start,
  input  logic                   i_stop,
  output logic                   o_tick,
  output logic                   o_busy,
  output logic [CNT_WIDTH-1:0]   o_cnt
);

  logic [0:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [PRESC_WIDTH-1:0] div_q, div_d;
  logic                   mode_q, mode_d;

  logic running_c;
  logic step_c;
  logic term_c;
  logic presc_clr_c;

  assign running_c = (state_q == ST_RUN);
  assign term_c    = step_c && (cnt_q == period_q);

  tick_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr    (presc_clr_c),
    .en     (running_c),
    .div    (div_q),
    .step_c (step_c)
  );

  // Next-state: start beats stop; stop and one-shot terminal return to idle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    div_d       = div_q;
    mode_d      = mode_q;
    presc_clr_c = 1'b0;

    if (i_start) begin
      period_d    = i_period;
      div_d       = i_presc;
      mode_d      = i_mode;
      cnt_d       = '0;
      presc_clr_c = 1'b1;
      state_d     = ST_RUN;
    end else if (running_c) begin
      if (i_stop) begin
        cnt_d       = '0;
        presc_clr_c = 1'b1;
        state_d     = ST_IDLE;
      end else if (step_c) begin
        if (cnt_q == period_q) begin
          cnt_d = '0;
          if (mode_q == MODE_ONESHOT) begin
            presc_clr_c = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      div_q    <= '0;
      mode_q   <= MODE_PERIODIC;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
    end
  end

  // Tick is a decode of registers only; gated so a reset cycle never ticks
  assign o_tick = term_c && !rst;
  assign o_busy = running_c;
  assign o_cnt  = cnt_q;

endmodule : tick_timer

// File: tb/tb_tick_timer.sv
// Scoreboard bench for tick_timer: stimulus pushes expected tick cycles,
// a negedge monitor pops and compares whenever a tick appears.
module tb_tick_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_period;
  logic [7:0]  i_presc;
  logic        i_mode, i_start, i_stop;
  logic        o_tick, o_busy;
  logic [15:0] o_cnt;

  logic [3:0]  p4;
  logic [7:0]  presc4;
  logic        mode4, start4, stop4;
  logic        tick4, busy4;
  logic [3:0]  cnt4;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int exp4_q[$];
  int e_main, e4;
  int c0, c1, c2;
  int t2_cnt[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_timer #(.CNT_WIDTH(16), .PRESC_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_period(i_period), .i_presc(i_presc),
    .i_mode(i_mode), .i_start(i_start), .i_stop(i_stop),
    .o_tick(o_tick), .o_busy(o_busy), .o_cnt(o_cnt)
  );

  tick_timer #(.CNT_WIDTH(4), .PRESC_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .i_period(p4), .i_presc(presc4),
    .i_mode(mode4), .i_start(start4), .i_stop(stop4),
    .o_tick(tick4), .o_busy(busy4), .o_cnt(cnt4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic start_main(input logic [15:0] p, input logic [7:0] d,
                            input logic m, input logic stp, output int c);
    i_period = p;
    i_presc  = d;
    i_mode   = m;
    i_start  = 1'b1;
    i_stop   = stp;
    c = cyc;
    adv();
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  // Tick monitor: every tick must match the oldest expected cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      e_main = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_tick: no tick seen, required tick at cycle %0d", e_main);
    end
    if (o_tick) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: tick at cycle %0d, required none", cyc);
      end else begin
        e_main = exp_q.pop_front();
        if (e_main != cyc) begin
          n_fail++;
          $display("FAIL tick_cycle: tick at cycle %0d, required %0d", cyc, e_main);
        end
      end
    end
    if (exp4_q.size() > 0 && exp4_q[0] < cyc) begin
      e4 = exp4_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_tick4: no tick seen, required tick at cycle %0d", e4);
    end
    if (tick4) begin
      n_checks++;
      if (exp4_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick4: tick at cycle %0d, required none", cyc);
      end else begin
        e4 = exp4_q.pop_front();
        if (e4 != cyc) begin
          n_fail++;
          $display("FAIL tick4_cycle: tick at cycle %0d, required %0d", cyc, e4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_period = '0; i_presc = '0; i_mode = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    p4 = '0; presc4 = '0; mode4 = 1'b0; start4 = 1'b0; stop4 = 1'b0;

    // 1: reset then idle
    repeat (3) adv();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("idle_tick", int'(o_tick), 0);
      chk("idle_busy", int'(o_busy), 0);
      chk("idle_cnt", int'(o_cnt), 0);
      adv();
    end
    chk("idle_busy4", int'(busy4), 0);

    // 2: periodic P=3 D=0, ticks at 4, 8, 12
    start_main(16'd3, 8'd0, 1'b0, 1'b0, c0);
    exp_q.push_back(c0 + 4);
    exp_q.push_back(c0 + 8);
    exp_q.push_back(c0 + 12);
    for (int i = 0; i < 5; i++) begin
      chk("t2_cnt_seq", int'(o_cnt), t2_cnt[i]);
      adv();
    end
    repeat (6) adv();
    chk("t2_tick12", int'(o_tick), 1);
    i_stop = 1'b1;
    adv();
    i_stop = 1'b0;
    chk("t2_stop_busy", int'(o_busy), 0);
    chk("t2_stop_cnt", int'(o_cnt), 0);

    // 3: one-shot P=2 D=4, single tick at 15
    start_main(16'd2, 8'd4, 1'b1, 1'b0, c0);
    exp_q.push_back(c0 + 15);
    chk("t3_busy_start", int'(o_busy), 1);
    repeat (14) adv();
    chk("t3_busy_at_tick", int'(o_busy), 1);
    chk("t3_cnt_at_tick", int'(o_cnt), 2);
    adv();
    chk("t3_busy_after", int'(o_busy), 0);
    chk("t3_cnt_after", int'(o_cnt), 0);
    repeat (50) adv();
    chk("t3_busy_late", int'(o_busy), 0);

    // 4: restart mid-period, then start+stop together
    start_main(16'd3, 8'd0, 1'b0, 1'b0, c0);
    adv();
    chk("t4_cnt_before", int'(o_cnt), 1);
    start_main(16'd1, 8'd0, 1'b0, 1'b0, c1);
    exp_q.push_back(c1 + 2);
    chk("t4_cnt_restart", int'(o_cnt), 0);
    adv();
    chk("t4_tick", int'(o_tick), 1);
    chk("t4_cnt_tick", int'(o_cnt), 1);
    adv();
    start_main(16'd1, 8'd0, 1'b0, 1'b1, c2);
    exp_q.push_back(c2 + 2);
    chk("t4_startstop_busy", int'(o_busy), 1);
    chk("t4_startstop_cnt", int'(o_cnt), 0);
    adv();
    adv();
    i_stop = 1'b1;
    adv();
    i_stop = 1'b0;
    chk("t4_stop_busy", int'(o_busy), 0);

    // 5: P=0 D=1, period port change ignored, stop on tick cycle
    start_main(16'd0, 8'd1, 1'b0, 1'b0, c0);
    exp_q.push_back(c0 + 2);
    exp_q.push_back(c0 + 4);
    exp_q.push_back(c0 + 6);
    i_period = 16'd5;
    chk("t5_tick_c1", int'(o_tick), 0);
    repeat (5) adv();
    chk("t5_tick_c6", int'(o_tick), 1);
    chk("t5_cnt_c6", int'(o_cnt), 0);
    i_stop = 1'b1;
    adv();
    i_stop = 1'b0;
    chk("t5_stop_busy", int'(o_busy), 0);
    chk("t5_stop_cnt", int'(o_cnt), 0);
    repeat (10) adv();

    // 6: reset on a tick cycle suppresses the tick
    start_main(16'd1, 8'd0, 1'b0, 1'b0, c0);
    adv();
    rst = 1'b1;
    #1;
    chk("t6_tick_in_reset", int'(o_tick), 0);
    adv();
    rst = 1'b0;
    chk("t6_busy_after_rst", int'(o_busy), 0);
    chk("t6_cnt_after_rst", int'(o_cnt), 0);
    repeat (5) adv();
    chk("t6_busy_late", int'(o_busy), 0);

    // 6b: 4-bit counter at all-ones, tick every 16 cycles
    p4 = 4'hF; presc4 = 8'd0; mode4 = 1'b0; start4 = 1'b1;
    c0 = cyc;
    adv();
    start4 = 1'b0;
    exp4_q.push_back(c0 + 16);
    exp4_q.push_back(c0 + 32);
    exp4_q.push_back(c0 + 48);
    repeat (15) adv();
    chk("t6_tick4_c16", int'(tick4), 1);
    chk("t6_cnt4_c16", int'(cnt4), 15);
    adv();
    chk("t6_cnt4_wrap", int'(cnt4), 0);
    repeat (31) adv();
    chk("t6_tick4_c48", int'(tick4), 1);
    stop4 = 1'b1;
    adv();
    stop4 = 1'b0;
    chk("t6_busy4_stop", int'(busy4), 0);
    repeat (5) adv();

    chk("main_queue_drained", exp_q.size(), 0);
    chk("q4_drained", exp4_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tick_timer

// File: doc/tick_timer.md
Name: tick_timer

Overview:
Runtime-programmable tick generator. It is the successor to the fixed-parameter enable counter.
- Adds a prescaler, period and divider loadable at run time, periodic or one-shot mode, and start/stop control.
- Produces a one-cycle o_tick strobe used as a baud/sample/refresh enable by UART, ROM-reader and display blocks.
- Single clock domain.

Parameters:
- CNT_WIDTH, 16, width of main counter and i_period
- PRESC_WIDTH, 8, width of prescaler counter and i_presc

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- i_period  in  CNT_WIDTH  terminal value P; tick period is P+1 steps
- i_presc  in  PRESC_WIDTH  divider D; one step every D+1 clk cycles
- i_mode  in  1  0 = periodic (auto-reload), 1 = one-shot
- i_start  in  1  load config and (re)start counting
- i_stop  in  1  halt counting, return to idle
- o_tick  out  1  one-cycle strobe at terminal count
- o_busy  out  1  high while running
- o_cnt  out  CNT_WIDTH  current main count value

Behaviour:
Clock, reset and polarity:
- One clock, clk; reset rst is synchronous and active-high.
- While rst is high at a clk edge: state IDLE, cnt=0, presc=0, latched P/D/mode=0. Outputs are o_tick=0, o_busy=0, o_cnt=0.
- Reset mid-run aborts immediately. A tick pending in the reset cycle is suppressed; o_tick is gated by !rst.

States:
- IDLE, RUN. o_busy = (state==RUN).

Configuration latch:
- On a clk edge with i_start=1, latch P=i_period, D=i_presc, mode=i_mode; clear cnt=0 and presc=0; go to RUN.
- Port values are ignored at all other times, so changing them while running has no effect until the next i_start.

Step and tick:
- step = RUN && (presc==D). Output o_tick = step && (cnt==P), a combinational decode of registers only.
- In RUN, each cycle: if step then presc<=0, else presc<=presc+1.
- On step: if cnt==P then cnt<=0, else cnt<=cnt+1.

Tick timing:
- First tick is asserted during the (P+1)*(D+1)-th cycle after the start edge.
- In periodic mode, ticks then repeat every (P+1)*(D+1) cycles.
- P=0, D=0 gives o_tick high every cycle while running.

One-shot mode:
- The cycle o_tick is high, the next edge moves the block to IDLE with cnt=0 and presc=0.

Control priority (highest first):
- rst, then i_start, then i_stop.
- i_start while RUN restarts from zero with new config. No tick is issued for the aborted period unless o_tick was already high that cycle.
- i_start and i_stop in the same cycle: start wins.
- i_stop in RUN: next edge goes to IDLE and clears cnt and presc. If o_tick is high in that same cycle it is still emitted.
- i_stop in IDLE: no effect.

Arithmetic:
- Counters are unsigned and increment by 1 at their own width.
- cnt never exceeds P and presc never exceeds D, so no wrap occurs.
- P and D at all-ones are legal.

In IDLE:
- cnt and presc hold 0; o_tick=0.

Decomposition:
- Shared package: mode encoding constants MODE_PERIODIC=1'b0 and MODE_ONESHOT=1'b1, and the state encoding ST_IDLE/ST_RUN.
- One sub-module is natural: tick_prescaler. It holds the presc register, its clear/enable inputs and the step output, and is reused by other timing blocks.
- The main counter and FSM stay in tick_timer.

Test Plan:
1. Reset and idle: rst=1 for 3 cycles, then idle 10 cycles -> o_tick=0, o_busy=0, o_cnt=0 throughout.
2. Periodic, unit divider: start with P=3, D=0, mode=0 -> o_tick high on cycles 4, 8 and 12 after the start edge, o_cnt sequence 0,1,2,3,0.
3. Prescaled one-shot: start with P=2, D=4, mode=1 -> single tick at cycle 15, o_busy falls on the next edge, no further ticks over 50 cycles.
4. Restart and priority: mid-period i_start with P=1, D=0 -> cnt restarts at 0 and the next tick lands 2 cycles later. i_start and i_stop together -> still running.
5. Stop on tick cycle: P=0, D=1, assert i_stop on a cycle where o_tick=1 -> that tick is seen, then o_busy=0 and no more ticks. Also change i_period while running -> period unchanged.
6. Reset mid-run: rst=1 on a cycle where o_tick would be high -> o_tick=0, and the next cycle shows o_busy=0, o_cnt=0. Run one extreme case with P=all-ones, D=0 and CNT_WIDTH=4 -> tick every 16 cycles.
